riscv_membuf_ot: RTL and testbench
==================================

Name: riscv_membuf_ot

Overview:
Parametrised memory-access buffer between the CPU load/store path and the BIU/cache.
- Queues CPU requests and cache-maintenance commands in order.
- Optionally bypasses an empty queue with zero latency.
- Tracks in-flight requests awaiting ack_i and caps them at OUTSTANDING.
- Holds cache-maintenance commands at the head until all in-flight accesses have drained.

Parameters:
DEPTH, 4, number of queue entries; power of 2, minimum 2.
XLEN, 32, address/data width.
OUTSTANDING, 2, maximum issued-but-unacked requests; minimum 1.
BYPASS, 1, 1 = empty queue passes inputs straight through; 0 = always at least 1 cycle latency.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  discard all queued (not-yet-issued) entries
stall_i  in  1  downstream cannot take req_o this cycle
req_i  in  1  CPU access request
adr_i  in  XLEN  access address
size_i  in  biu_size_t  access size
lock_i  in  1  locked access
prot_i  in  biu_prot_t  protection attributes
we_i  in  1  write enable
d_i  in  XLEN  write data
cm_clean_i  in  1  cache clean command
cm_invalidate_i  in  1  cache invalidate command
ready_o  out  1  buffer accepts a new entry (= !full_o)
req_o  out  1  head access presented downstream
ack_i  in  1  one issued request completed
adr_o, size_o, lock_o, prot_o, we_o  out  as inputs  head attributes
q_o  out  XLEN  head write data
cm_clean_o, cm_invalidate_o  out  1  head maintenance command
empty_o  out  1  queue empty
full_o  out  1  queue holds DEPTH entries
inflight_o  out  $clog2(OUTSTANDING+1)  issued-unacked count

Behaviour:
- Reset: queue empty, pointers 0, inflight 0.
  - empty_o=1, full_o=0, ready_o=1, inflight_o=0.
  - req_o/cm_*_o follow the bypass path when BYPASS=1, else 0.
- Entry: valid input = req_i | cm_clean_i | cm_invalidate_i.
  - Accepted only when ready_o=1; the upstream holds inputs while ready_o=0.
- Head source:
  - Queue not empty: queue head.
  - Queue empty and BYPASS=1: inputs directly.
  - Queue empty and BYPASS=0: nothing; req_o=0, cm_*_o=0.
- Issue gating:
  - Access head: req_o = head_valid & (inflight < OUTSTANDING).
  - Maintenance head: cm_*_o asserted only when inflight==0; no access issued past it.
  - Issue fires when (req_o | cm_*_o) & !stall_i.
- Queue write: valid input accepted and not consumed by the bypass issue in the same cycle.
- Queue pop: issue fires and the head came from the queue.
- Simultaneous write and pop with the queue full cannot occur, because ready_o=0 blocks the write.
- Pointers are circular mod DEPTH. Count width is $clog2(DEPTH)+1.
- inflight counter:
  - +1 on an access issue, -1 on ack_i; both in the same cycle leaves it unchanged.
  - ack_i at 0 is ignored and the counter saturates at 0.
  - Maintenance issues do not count.
- flush_i (synchronous, highest priority over queue ops):
  - Clears the queue next cycle.
  - Inputs presented in the same cycle are dropped and no issue fires that cycle.
  - inflight is preserved, because acks for already-issued requests still arrive.
- Ordering: strict FIFO. A bypass is only possible when the queue is empty, so younger requests never overtake.
- Reset mid-operation clears all state immediately. Late acks after reset are ignored (counter at 0).
- Outputs are combinational from the head; no registered latency when the queue is non-empty.

Decomposition:
- Shared package biu_constants_pkg: biu_size_t and biu_prot_t (existing). No new package typedefs.
- Entry struct (depends on XLEN): local typedef in the module.
- Sub-module riscv_membuf_fifo: circular-buffer storage with we/re/clr, empty/full and count.
- Top level holds bypass select, issue gating and the inflight counter.

Test Plan:
1. BYPASS=1, empty, stall_i=0, req_i=1, adr_i=0x100 -> req_o=1 and adr_o=0x100 the same cycle, empty_o stays 1, inflight_o=1 next cycle.
2. stall_i=1, 4 consecutive requests 0x0/0x4/0x8/0xC (DEPTH=4) -> full_o=1 and ready_o=0 after the 4th; release stall -> issues in order 0x0, 0x4 and then stops with inflight=2 (OUTSTANDING=2); one ack_i -> 0x8 issues the next cycle.
3. Queue holds an access and a cm_invalidate, inflight=2 -> the access issues after the first ack; cm_invalidate_o stays 0 until inflight==0, then asserts for 1 cycle and pops.
4. Queue holds 3 entries, inflight=1, flush_i=1 together with req_i=1 -> the next cycle empty_o=1, the new request is not stored, inflight_o=1; ack_i -> inflight_o=0.
5. ack_i together with an issue at inflight=1 -> inflight_o remains 1; spurious ack_i at inflight 0 -> stays 0.
6. BYPASS=0, empty, req_i=1 adr_i=0x20 -> req_o=0 that cycle; next cycle req_o=1, adr_o=0x20; rst_ni low mid-queue -> empty_o=1 and inflight_o=0 asynchronously.

Source files
------------

// File: rtl/biu_constants_pkg.sv
// Shared BIU type definitions used by the load/store path and the bus interface.
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3,
    QWORD = 3'd4
  } biu_size_t;

  // Bit 0: privileged, bit 1: non-secure, bit 2: instruction fetch
  typedef logic [2:0] biu_prot_t;

  localparam biu_prot_t PROT_DATA       = 3'b000;
  localparam biu_prot_t PROT_PRIVILEGED = 3'b001;
  localparam biu_prot_t PROT_NONSECURE  = 3'b010;
  localparam biu_prot_t PROT_INSTRUCTION = 3'b100;

endpackage

// File: rtl/riscv_membuf_fifo.sv
// Circular-buffer storage for the memory buffer; clear has priority over write/read.
module riscv_membuf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr,
  input  logic                     we,
  input  logic                     re,
  input  logic [WIDTH-1:0]         d,
  output logic [WIDTH-1:0]         q,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_write, do_read;

  assign do_write = we & ~full & ~clr;
  assign do_read  = re & ~empty & ~clr;

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (do_read)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_write, do_read})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write) mem[wr_ptr] <= d;
  end

  assign q     = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign count = cnt;

endmodule

// File: rtl/riscv_membuf_ot.sv
// In-order memory access buffer with optional empty-queue bypass, outstanding-request
// cap and cache-maintenance drain ordering.
module riscv_membuf_ot
  import biu_constants_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int XLEN        = 32,
  parameter int OUTSTANDING = 2,
  parameter int BYPASS      = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic                                 stall_i,
  input  logic                                 req_i,
  input  logic [XLEN-1:0]                      adr_i,
  input  biu_size_t                            size_i,
  input  logic                                 lock_i,
  input  biu_prot_t                            prot_i,
  input  logic                                 we_i,
  input  logic [XLEN-1:0]                      d_i,
  input  logic                                 cm_clean_i,
  input  logic                                 cm_invalidate_i,
  output logic                                 ready_o,
  output logic                                 req_o,
  input  logic                                 ack_i,
  output logic [XLEN-1:0]                      adr_o,
  output biu_size_t                            size_o,
  output logic                                 lock_o,
  output biu_prot_t                            prot_o,
  output logic                                 we_o,
  output logic [XLEN-1:0]                      q_o,
  output logic                                 cm_clean_o,
  output logic                                 cm_invalidate_o,
  output logic                                 empty_o,
  output logic                                 full_o,
  output logic [$clog2(OUTSTANDING+1)-1:0]     inflight_o
);

  localparam int INFW = $clog2(OUTSTANDING + 1);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam logic [INFW-1:0] MAX_INFLIGHT = INFW'(OUTSTANDING);

  typedef struct packed {
    logic [XLEN-1:0] adr;
    biu_size_t       size;
    logic            lock;
    biu_prot_t       prot;
    logic            we;
    logic [XLEN-1:0] d;
    logic            cm_clean;
    logic            cm_invalidate;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t           in_entry, q_entry, head;
  logic [EW-1:0]    fifo_q;
  logic [CW-1:0]    q_count;
  logic             q_empty, q_full;
  logic             in_valid, head_valid, head_is_cm, can_issue;
  logic             issue, access_issue, ack_dec;
  logic             fifo_we, fifo_re;
  logic [INFW-1:0]  inflight_q;

  assign in_valid = req_i | cm_clean_i | cm_invalidate_i;

  assign in_entry.adr           = adr_i;
  assign in_entry.size          = size_i;
  assign in_entry.lock          = lock_i;
  assign in_entry.prot          = prot_i;
  assign in_entry.we            = we_i;
  assign in_entry.d             = d_i;
  assign in_entry.cm_clean      = cm_clean_i;
  assign in_entry.cm_invalidate = cm_invalidate_i;

  riscv_membuf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr    (flush_i),
    .we     (fifo_we),
    .re     (fifo_re),
    .d      (in_entry),
    .q      (fifo_q),
    .empty  (q_empty),
    .full   (q_full),
    .count  (q_count)
  );

  assign q_entry = entry_t'(fifo_q);

  // With an empty queue the inputs themselves become the head when bypass is enabled
  assign head       = q_empty ? in_entry : q_entry;
  assign head_valid = ~q_empty | ((BYPASS != 0) & in_valid);
  assign head_is_cm = head.cm_clean | head.cm_invalidate;
  assign can_issue  = head_valid & ~flush_i;

  // Maintenance waits for every in-flight access to be acknowledged
  assign req_o           = can_issue & ~head_is_cm & (inflight_q < MAX_INFLIGHT);
  assign cm_clean_o      = can_issue & head.cm_clean & (inflight_q == '0);
  assign cm_invalidate_o = can_issue & head.cm_invalidate & (inflight_q == '0);

  assign issue        = (req_o | cm_clean_o | cm_invalidate_o) & ~stall_i;
  assign access_issue = req_o & ~stall_i;

  assign fifo_we = in_valid & ~q_full & ~flush_i & ~(issue & q_empty);
  assign fifo_re = issue & ~q_empty;

  assign adr_o  = head.adr;
  assign size_o = head.size;
  assign lock_o = head.lock;
  assign prot_o = head.prot;
  assign we_o   = head.we;
  assign q_o    = head.d;

  assign ready_o = ~q_full;
  assign empty_o = q_empty;
  assign full_o  = q_full;

  assign ack_dec = ack_i & (inflight_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
    end else begin
      case ({access_issue, ack_dec})
        2'b10:   inflight_q <= inflight_q + INFW'(1);
        2'b01:   inflight_q <= inflight_q - INFW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign inflight_o = inflight_q;

  a_count_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    q_count <= CW'(DEPTH));

endmodule

// File: tb/tb_riscv_membuf_ot.sv
// Randomized bench for riscv_membuf_ot: a bypass and a non-bypass instance share stimulus
// and are each checked against a queue-based reference model.
module tb_riscv_membuf_ot;
  import biu_constants_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int OUTST = 2;

  typedef struct packed {
    logic [31:0] adr;
    logic [2:0]  size;
    logic        lock;
    logic [2:0]  prot;
    logic        we;
    logic [31:0] d;
    logic        cmc;
    logic        cmi;
  } tbEntry_t;

  logic clk = 1'b0;
  logic rstN;
  logic flushI, stallI, reqI, lockI, weI, cmCleanI, cmInvI, ackI;
  logic [XLEN-1:0] adrI, dI;
  biu_size_t sizeI;
  biu_prot_t protI;

  logic            readyO [2];
  logic            reqO [2];
  logic [XLEN-1:0] adrO [2];
  biu_size_t       sizeO [2];
  logic            lockO [2];
  biu_prot_t       protO [2];
  logic            weO [2];
  logic [XLEN-1:0] qO [2];
  logic            cmcO [2];
  logic            cmiO [2];
  logic            emptyO [2];
  logic            fullO [2];
  logic [1:0]      inflightO [2];

  int totalChecks = 0;
  int badChecks   = 0;

  tbEntry_t mq [2][8];
  int       mSize [2];
  int       mInf [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    riscv_membuf_ot #(
      .DEPTH(DEPTH), .XLEN(XLEN), .OUTSTANDING(OUTST), .BYPASS(g == 0 ? 1 : 0)
    ) dut (
      .clk_i           (clk),
      .rst_ni          (rstN),
      .flush_i         (flushI),
      .stall_i         (stallI),
      .req_i           (reqI),
      .adr_i           (adrI),
      .size_i          (sizeI),
      .lock_i          (lockI),
      .prot_i          (protI),
      .we_i            (weI),
      .d_i             (dI),
      .cm_clean_i      (cmCleanI),
      .cm_invalidate_i (cmInvI),
      .ready_o         (readyO[g]),
      .req_o           (reqO[g]),
      .ack_i           (ackI),
      .adr_o           (adrO[g]),
      .size_o          (sizeO[g]),
      .lock_o          (lockO[g]),
      .prot_o          (protO[g]),
      .we_o            (weO[g]),
      .q_o             (qO[g]),
      .cm_clean_o      (cmcO[g]),
      .cm_invalidate_o (cmiO[g]),
      .empty_o         (emptyO[g]),
      .full_o          (fullO[g]),
      .inflight_o      (inflightO[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Compare one instance against the model for the current inputs, then advance the model
  task automatic checkInst(input int k);
    bit byp, inValid, fromQ, hv, isCm, eReq, eCmc, eCmi, issue, accepted;
    tbEntry_t inE, h;
    int newInf;
    byp     = (k == 0);
    inValid = reqI | cmCleanI | cmInvI;
    inE.adr = adrI; inE.size = sizeI; inE.lock = lockI; inE.prot = protI;
    inE.we  = weI;  inE.d = dI;       inE.cmc = cmCleanI; inE.cmi = cmInvI;
    fromQ = (mSize[k] > 0);
    h     = fromQ ? mq[k][0] : inE;
    hv    = fromQ || (byp && inValid);
    isCm  = h.cmc | h.cmi;
    eReq  = hv && !isCm && (mInf[k] < OUTST) && !flushI;
    eCmc  = hv && h.cmc && (mInf[k] == 0) && !flushI;
    eCmi  = hv && h.cmi && (mInf[k] == 0) && !flushI;
    issue = (eReq || eCmc || eCmi) && !stallI;

    checkOutput($sformatf("ready_o[%0d]", k), 64'(readyO[k]), 64'(mSize[k] < DEPTH));
    checkOutput($sformatf("empty_o[%0d]", k), 64'(emptyO[k]), 64'(mSize[k] == 0));
    checkOutput($sformatf("full_o[%0d]", k), 64'(fullO[k]), 64'(mSize[k] == DEPTH));
    checkOutput($sformatf("inflight_o[%0d]", k), 64'(inflightO[k]), 64'(mInf[k]));
    checkOutput($sformatf("req_o[%0d]", k), 64'(reqO[k]), 64'(eReq));
    checkOutput($sformatf("cm_clean_o[%0d]", k), 64'(cmcO[k]), 64'(eCmc));
    checkOutput($sformatf("cm_inv_o[%0d]", k), 64'(cmiO[k]), 64'(eCmi));
    if (hv) begin
      checkOutput($sformatf("adr_o[%0d]", k), 64'(adrO[k]), 64'(h.adr));
      checkOutput($sformatf("q_o[%0d]", k), 64'(qO[k]), 64'(h.d));
      checkOutput($sformatf("attr[%0d]", k),
                  64'({sizeO[k], lockO[k], protO[k], weO[k]}),
                  64'({h.size, h.lock, h.prot, h.we}));
    end

    accepted = inValid && (mSize[k] < DEPTH) && !flushI;
    if (flushI) begin
      mSize[k] = 0;
    end else begin
      if (issue && fromQ) begin
        for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
        mSize[k]--;
      end
      if (accepted && !(issue && !fromQ)) begin
        mq[k][mSize[k]] = inE;
        mSize[k]++;
      end
    end
    newInf = mInf[k];
    if (issue && eReq) newInf++;
    if (ackI && mInf[k] > 0) newInf--;
    mInf[k] = newInf;
  endtask

  task automatic applyStimulus(input bit req, input bit cmc, input bit cmi, input logic [31:0] adr,
                               input bit stall, input bit flush, input bit ack);
    reqI = req; cmCleanI = cmc; cmInvI = cmi; adrI = adr;
    stallI = stall; flushI = flush; ackI = ack;
    sizeI = biu_size_t'($urandom_range(0, 2));
    lockI = 1'($urandom); protI = 3'($urandom); weI = 1'($urandom); dI = $urandom;
    #1;
    checkInst(0);
    checkInst(1);
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    reqI = 0; cmCleanI = 0; cmInvI = 0; stallI = 0; flushI = 0; ackI = 0;
    adrI = '0; dI = '0; lockI = 0; weI = 0; protI = '0; sizeI = BYTE;
  endtask

  // Async reset: state must clear without waiting for a clock edge
  task automatic resetAndCheck();
    clearInputs();
    rstN = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("rst_empty[%0d]", k), 64'(emptyO[k]), 64'd1);
      checkOutput($sformatf("rst_full[%0d]", k), 64'(fullO[k]), 64'd0);
      checkOutput($sformatf("rst_ready[%0d]", k), 64'(readyO[k]), 64'd1);
      checkOutput($sformatf("rst_inflight[%0d]", k), 64'(inflightO[k]), 64'd0);
      checkOutput($sformatf("rst_req[%0d]", k), 64'(reqO[k]), 64'd0);
      mSize[k] = 0;
      mInf[k]  = 0;
    end
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b1;
    clearInputs();
    mSize[0] = 0; mSize[1] = 0; mInf[0] = 0; mInf[1] = 0;
    #2;
    resetAndCheck();

    applyStimulus(1, 0, 0, 32'h100, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);

    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 32'(4 * i), 1, 0, 0);
    applyStimulus(1, 0, 0, 32'h40, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 32'h0, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 0, 1, 32'h0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 32'h200 + 32'(4 * i), 1, 0, 0);
    applyStimulus(1, 0, 0, 32'h300, 0, 1, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      int kind;
      if (i == 1500) resetAndCheck();
      kind = $urandom_range(0, 99);
      applyStimulus(kind < 50, kind >= 50 && kind < 56, kind >= 56 && kind < 62,
                    $urandom & 32'hFFFF_FFFC,
                    $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 4,
                    $urandom_range(0, 99) < 40);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
